bit_sync: RTL and testbench

Multi-bit clock-domain-crossing synchronizer for the destination (CLK) domain.
- The single-bit qualifier BUS_ENABLE passes through a NUM_STAGES flip-flop chain.
- A rising-edge detector turns the synchronized level into a one-cycle enable_pulse.
- On that pulse, UNSYNC_BUS is captured into the SYNC_BUS holding register.
- Sits at the receive side of any bus crossing where the source holds data stable while BUS_ENABLE is asserted.

---
 rtl/bit_sync.sv | 96 +++++++++
 tb/tb_bit_sync.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync -- multi-bit CDC receiver for the destination (CLK) domain.
//
// A single-bit qualifier (BUS_ENABLE) is passed through a NUM_STAGES deep
// flip-flop synchronizer. A rising-edge detector on the synchronized level
// produces a one-cycle strobe. On that strobe the source bus, which the
// sender holds stable while BUS_ENABLE is high, is captured into SYNC_BUS.
//
// Parameters:
//   NUM_STAGES  depth of the BUS_ENABLE synchronizer chain (2..8)
//   BUS_WIDTH   width of UNSYNC_BUS / SYNC_BUS (1..64)
//
// Ports:
//   CLK           in   destination clock, rising edge
//   RST           in   synchronous reset, active low
//   UNSYNC_BUS    in   source-domain data, stable while BUS_ENABLE is high
//   BUS_ENABLE    in   asynchronous data-valid level from the source domain
//   SYNC_BUS      out  registered copy of UNSYNC_BUS, updated on the strobe
//   enable_pulse  out  one-cycle strobe, high when SYNC_BUS first shows data
//   SYNC_ENABLE   out  (only with BIT_SYNC_LEVEL_OUT_EN defined) synchronized
//                      level of BUS_ENABLE, i.e. the last chain stage
//
// Build option:
//   BIT_SYNC_LEVEL_OUT_EN  when defined, adds the SYNC_ENABLE output port.
// ---------------------------------------------------------------------------
module bit_sync #(
    parameter int NUM_STAGES = 3,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
`ifdef BIT_SYNC_LEVEL_OUT_EN
    output logic                 SYNC_ENABLE,
`endif
    output logic                 enable_pulse
);

    generate
        if (NUM_STAGES < 2) begin : g_bad_stages
            $error("bit_sync: NUM_STAGES must be at least 2");
        end
        if (BUS_WIDTH < 1) begin : g_bad_width
            $error("bit_sync: BUS_WIDTH must be at least 1");
        end
    endgenerate

    logic [NUM_STAGES-1:0] r_sync_stages;
    logic                  r_pulse_flop;
    logic                  r_enable_pulse;
    logic [BUS_WIDTH-1:0]  r_sync_bus;
    logic                  w_sync_level;
    logic                  w_pulse_comb;

    // Plain shift chain: stage[0] samples the asynchronous level, nothing
    // sits between stages so each flop gets a full cycle to resolve.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sync_stages <= '0;
        end else begin
            r_sync_stages <= {r_sync_stages[NUM_STAGES-2:0], BUS_ENABLE};
        end
    end

    assign w_sync_level = r_sync_stages[NUM_STAGES-1];

    // Rising edge of the synchronized level; a held or falling level
    // yields no strobe.
    assign w_pulse_comb = w_sync_level & ~r_pulse_flop;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pulse_flop   <= 1'b0;
            r_enable_pulse <= 1'b0;
            r_sync_bus     <= '0;
        end else begin
            r_pulse_flop   <= w_sync_level;
            r_enable_pulse <= w_pulse_comb;
            // The bus is only looked at on the strobe, when the source is
            // guaranteed to be holding it stable.
            if (w_pulse_comb) begin
                r_sync_bus <= UNSYNC_BUS;
            end
        end
    end

    assign SYNC_BUS     = r_sync_bus;
    assign enable_pulse = r_enable_pulse;

`ifdef BIT_SYNC_LEVEL_OUT_EN
    assign SYNC_ENABLE  = w_sync_level;
`endif

endmodule

// File: tb/tb_bit_sync.sv
module tb_bit_sync;

    logic       CLK;
    logic       RST;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic [7:0] sync_bus;
    logic       enable_pulse;
    logic [0:0] unsync_bus2;
    logic       bus_enable2;
    logic [0:0] sync_bus2;
    logic       enable_pulse2;
`ifdef BIT_SYNC_LEVEL_OUT_EN
    logic       sync_enable;
    logic       sync_enable2;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    bit_sync #(.NUM_STAGES(3), .BUS_WIDTH(8)) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .UNSYNC_BUS   (unsync_bus),
        .BUS_ENABLE   (bus_enable),
        .SYNC_BUS     (sync_bus),
`ifdef BIT_SYNC_LEVEL_OUT_EN
        .SYNC_ENABLE  (sync_enable),
`endif
        .enable_pulse (enable_pulse)
    );

    bit_sync #(.NUM_STAGES(2), .BUS_WIDTH(1)) u_dut2 (
        .CLK          (CLK),
        .RST          (RST),
        .UNSYNC_BUS   (unsync_bus2),
        .BUS_ENABLE   (bus_enable2),
        .SYNC_BUS     (sync_bus2),
`ifdef BIT_SYNC_LEVEL_OUT_EN
        .SYNC_ENABLE  (sync_enable2),
`endif
        .enable_pulse (enable_pulse2)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%0h", tag, got);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    int pulses;

    initial begin
        RST         = 1'b0;
        bus_enable  = 1'b0;
        unsync_bus  = 8'h00;
        bus_enable2 = 1'b0;
        unsync_bus2 = 1'b0;

        // ---------------- reset ----------------
        step();
        check_val("rst_pulse_e1", enable_pulse, 1'b0);
        check_val("rst_bus_e1", sync_bus, 8'h00);
        step();
        check_val("rst_pulse_e2", enable_pulse, 1'b0);
        check_val("rst_bus_e2", sync_bus, 8'h00);
`ifdef BIT_SYNC_LEVEL_OUT_EN
        check_val("rst_level", sync_enable, 1'b0);
`endif
        RST = 1'b1;
        step();

        // ---------------- basic transfer 0xBC ----------------
        unsync_bus = 8'hBC;
        bus_enable = 1'b1;
        step();                                     // edge k
        check_val("xfer1_k0_pulse", enable_pulse, 1'b0);
        step();                                     // k+1
        check_val("xfer1_k1_pulse", enable_pulse, 1'b0);
        step();                                     // k+2
        check_val("xfer1_k2_pulse", enable_pulse, 1'b0);
        check_val("xfer1_k2_bus", sync_bus, 8'h00);
`ifdef BIT_SYNC_LEVEL_OUT_EN
        check_val("xfer1_k2_level", sync_enable, 1'b1);
`endif
        step();                                     // k+3
        check_val("xfer1_k3_pulse", enable_pulse, 1'b1);
        check_val("xfer1_k3_bus", sync_bus, 8'hBC);
        step();                                     // k+4
        check_val("xfer1_k4_pulse", enable_pulse, 1'b0);
        check_val("xfer1_k4_bus", sync_bus, 8'hBC);

        // ---------------- held enable, data changes ----------------
        unsync_bus = 8'h55;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (enable_pulse) pulses++;
        end
        check_val("held_pulses", pulses, 0);
        check_val("held_bus", sync_bus, 8'hBC);

        // ---------------- deassert, then second transfer ----------------
        bus_enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (enable_pulse) pulses++;
        end
        check_val("fall_pulses", pulses, 0);
        check_val("fall_bus", sync_bus, 8'hBC);

        unsync_bus = 8'h3C;
        bus_enable = 1'b1;
        step();                                     // k
        step();                                     // k+1
        step();                                     // k+2
        check_val("xfer2_k2_pulse", enable_pulse, 1'b0);
        step();                                     // k+3
        check_val("xfer2_k3_pulse", enable_pulse, 1'b1);
        check_val("xfer2_k3_bus", sync_bus, 8'h3C);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (enable_pulse) pulses++;
        end
        check_val("xfer2_after_pulses", pulses, 0);
        check_val("xfer2_after_bus", sync_bus, 8'h3C);

        // ---------------- reset mid-flight ----------------
        bus_enable = 1'b0;
        for (int i = 0; i < 4; i++) step();
        unsync_bus = 8'hA5;
        bus_enable = 1'b1;
        step();                                     // stage[0] now high
        RST = 1'b0;
        step();
        check_val("midrst_pulse", enable_pulse, 1'b0);
        check_val("midrst_bus", sync_bus, 8'h00);
        step();
        check_val("midrst_pulse2", enable_pulse, 1'b0);
        RST = 1'b1;
        step();                                     // release edge 1
        check_val("rel_e1_pulse", enable_pulse, 1'b0);
        step();                                     // 2
        step();                                     // 3
        check_val("rel_e3_pulse", enable_pulse, 1'b0);
        check_val("rel_e3_bus", sync_bus, 8'h00);
        step();                                     // 4
        check_val("rel_e4_pulse", enable_pulse, 1'b1);
        check_val("rel_e4_bus", sync_bus, 8'hA5);
        step();                                     // 5
        check_val("rel_e5_pulse", enable_pulse, 1'b0);

        // ---------------- NUM_STAGES=2, BUS_WIDTH=1 ----------------
        check_val("p2_idle_bus", sync_bus2, 1'b0);
        unsync_bus2 = 1'b1;
        bus_enable2 = 1'b1;
        step();                                     // k
        check_val("p2_k0_pulse", enable_pulse2, 1'b0);
`ifdef BIT_SYNC_LEVEL_OUT_EN
        check_val("p2_k0_level", sync_enable2, 1'b0);
`endif
        step();                                     // k+1
        check_val("p2_k1_pulse", enable_pulse2, 1'b0);
        check_val("p2_k1_bus", sync_bus2, 1'b0);
`ifdef BIT_SYNC_LEVEL_OUT_EN
        check_val("p2_k1_level", sync_enable2, 1'b1);
`endif
        step();                                     // k+2
        check_val("p2_k2_pulse", enable_pulse2, 1'b1);
        check_val("p2_k2_bus", sync_bus2, 1'b1);
        step();                                     // k+3
        check_val("p2_k3_pulse", enable_pulse2, 1'b0);
        check_val("p2_k3_bus", sync_bus2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
